// File: rtl/forward_unit.sv
// Forwarding / hazard controller for the 32-bit ALU pipeline.
// Shadows the register writers in EX and MEM and produces registered 2-bit
// operand-mux selects for the instruction entering EX. Load-use hazards
// hold issue off until the load result can be forwarded. A flush removes
// the instruction in the EX shadow.
module forward_unit #(
  parameter int REG_AW      = 5,
  parameter int EXTRA_STALL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_regwrite,
  input  logic              iss_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;  // producer sits in EX/MEM
  localparam logic [1:0] SEL_WB  = 2'b10;  // producer sits in MEM/WB
  localparam logic [2:0] CNT_INIT = 3'(EXTRA_STALL);

  // Writer description shared by every shadow slot.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
  } wr_t;

  // The EX slot also records whether the writer is a load.
  typedef struct packed {
    wr_t  w;
    logic ld;
  } ex_slot_t;

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  // A writer that has reached WB is visible through the register file
  // (write-before-read), so it never affects forwarding or hazards and
  // only the EX and MEM shadows are kept.
  ex_slot_t ex_q, ex_d;
  wr_t      mem_q;
  state_t   state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic       stall_q, stall_d;
  logic       hazard, accept;

  function automatic logic match(input wr_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.we && (s.rd != '0) && (s.rd == r);
  endfunction

  // Newest producer wins: the EX shadow is checked before MEM.
  function automatic logic [1:0] pick(input wr_t ex, input wr_t mem,
                                      input logic [REG_AW-1:0] r);
    if (match(ex, r))       return SEL_MEM;
    else if (match(mem, r)) return SEL_WB;
    else                    return SEL_RF;
  endfunction

  // Issue handshake: a load in EX feeding either source holds issue off.
  always_comb begin
    hazard    = iss_valid && ex_q.ld &&
                (match(ex_q.w, iss_rs1) || match(ex_q.w, iss_rs2));
    iss_ready = (state_q == ST_RUN) && !hazard && !flush;
    accept    = iss_valid && iss_ready;
  end

  // Next-state for shadows, selects, stall flag and the stall FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch.
    ex_d    = '0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    stall_d = !flush && (hazard || (state_q == ST_STALL));
    state_d = state_q;
    cnt_d   = cnt_q;

    if (accept) begin
      ex_d.w.valid = 1'b1;
      ex_d.w.rd    = iss_rd;
      ex_d.w.we    = iss_regwrite;
      ex_d.ld      = iss_memread;
      sel_a_d      = pick(ex_q.w, mem_q, iss_rs1);
      sel_b_d      = pick(ex_q.w, mem_q, iss_rs2);
    end

    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard && (EXTRA_STALL != 0)) begin
            state_d = ST_STALL;
            cnt_d   = CNT_INIT;
          end
        end
        ST_STALL: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State registers; MEM always takes what was in EX, even across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
      stall_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      ex_q    <= ex_d;
      mem_q   <= ex_q.w;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      stall_q <= stall_d;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_forward_unit.sv
// Self-checking bench for forward_unit: a vector table on an EXTRA_STALL=0
// instance plus hand sequences on an EXTRA_STALL=2 instance and resets.
module tb_forward_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
  } iss_t;

  typedef struct {
    iss_t       in;
    logic       ready;
    logic [1:0] a;
    logic [1:0] b;
    logic       stall;
  } vec_t;

  localparam int NV = 23;

  logic clk, rst_n;
  iss_t in0, in2;
  logic ready0, ready2, stall0, stall2;
  logic [1:0] a0, b0, a2, b2;
  int n_pass, n_total;
  vec_t vecs [NV];

  forward_unit #(.REG_AW(5), .EXTRA_STALL(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(in0.valid), .iss_ready(ready0),
    .iss_rs1(in0.rs1), .iss_rs2(in0.rs2), .iss_rd(in0.rd),
    .iss_regwrite(in0.we), .iss_memread(in0.ld), .flush(in0.fl),
    .fwd_a_sel(a0), .fwd_b_sel(b0), .stall(stall0)
  );

  forward_unit #(.REG_AW(5), .EXTRA_STALL(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(in2.valid), .iss_ready(ready2),
    .iss_rs1(in2.rs1), .iss_rs2(in2.rs2), .iss_rd(in2.rd),
    .iss_regwrite(in2.we), .iss_memread(in2.ld), .flush(in2.fl),
    .fwd_a_sel(a2), .fwd_b_sel(b2), .stall(stall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d required %0d", name, act, exp);
    else n_pass++;
  endtask

  function automatic iss_t ins(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic ld,
                               input logic fl);
    iss_t x;
    x.valid = v; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.we = we; x.ld = ld; x.fl = fl;
    return x;
  endfunction

  function automatic vec_t mk(input iss_t in, input logic r, input logic [1:0] a,
                              input logic [1:0] b, input logic s);
    vec_t v;
    v.in = in; v.ready = r; v.a = a; v.b = b; v.stall = s;
    return v;
  endfunction

  initial begin
    iss_t nop, lw7, use7;
    int low_cnt;
    logic got;

    n_pass = 0; n_total = 0;
    nop = ins(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    lw7  = ins(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    use7 = ins(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);

    // {inputs during cycle, iss_ready that cycle, a/b/stall after the edge}
    vecs[0]  = mk(ins(1, 5'd1,  5'd2,  5'd5,  1, 0, 0), 1, 2'b00, 2'b00, 0); // add x5
    vecs[1]  = mk(ins(1, 5'd5,  5'd3,  5'd6,  1, 0, 0), 1, 2'b01, 2'b00, 0); // sub rs1=x5
    vecs[2]  = mk(ins(1, 5'd1,  5'd2,  5'd5,  1, 0, 0), 1, 2'b00, 2'b00, 0); // add x5
    vecs[3]  = mk(ins(1, 5'd1,  5'd2,  5'd9,  1, 0, 0), 1, 2'b00, 2'b00, 0); // or x9
    vecs[4]  = mk(ins(1, 5'd4,  5'd5,  5'd10, 1, 0, 0), 1, 2'b00, 2'b10, 0); // and rs2=x5
    vecs[5]  = mk(ins(1, 5'd1,  5'd2,  5'd5,  1, 0, 0), 1, 2'b00, 2'b00, 0); // add x5
    vecs[6]  = mk(ins(1, 5'd1,  5'd2,  5'd5,  1, 0, 0), 1, 2'b00, 2'b00, 0); // sub x5
    vecs[7]  = mk(ins(1, 5'd5,  5'd5,  5'd11, 1, 0, 0), 1, 2'b01, 2'b01, 0); // xor x5,x5
    vecs[8]  = mk(nop,                                  1, 2'b00, 2'b00, 0);
    vecs[9]  = mk(nop,                                  1, 2'b00, 2'b00, 0);
    vecs[10] = mk(ins(1, 5'd1,  5'd2,  5'd7,  1, 1, 0), 1, 2'b00, 2'b00, 0); // lw x7
    vecs[11] = mk(ins(1, 5'd7,  5'd3,  5'd8,  1, 0, 0), 0, 2'b00, 2'b00, 1); // load-use
    vecs[12] = mk(ins(1, 5'd7,  5'd3,  5'd8,  1, 0, 0), 1, 2'b10, 2'b00, 0); // re-issue
    vecs[13] = mk(ins(1, 5'd1,  5'd2,  5'd0,  1, 0, 0), 1, 2'b00, 2'b00, 0); // add x0
    vecs[14] = mk(ins(1, 5'd0,  5'd0,  5'd12, 1, 0, 0), 1, 2'b00, 2'b00, 0); // x0 never fwd
    vecs[15] = mk(ins(1, 5'd1,  5'd2,  5'd13, 1, 1, 0), 1, 2'b00, 2'b00, 0); // lw x13
    vecs[16] = mk(ins(1, 5'd3,  5'd13, 5'd14, 1, 0, 1), 0, 2'b00, 2'b00, 0); // hazard+flush
    vecs[17] = mk(ins(1, 5'd3,  5'd13, 5'd14, 1, 0, 0), 1, 2'b00, 2'b10, 0); // load in MEM
    vecs[18] = mk(ins(1, 5'd1,  5'd2,  5'd15, 0, 0, 0), 1, 2'b00, 2'b00, 0); // no regwrite
    vecs[19] = mk(ins(1, 5'd15, 5'd15, 5'd16, 1, 0, 0), 1, 2'b00, 2'b00, 0); // we=0 ignored
    vecs[20] = mk(ins(1, 5'd1,  5'd2,  5'd17, 1, 0, 1), 0, 2'b00, 2'b00, 0); // flush blocks
    vecs[21] = mk(ins(1, 5'd17, 5'd17, 5'd18, 1, 0, 0), 1, 2'b00, 2'b00, 0); // nothing in EX
    vecs[22] = mk(nop,                                  1, 2'b00, 2'b00, 0);

    // Power-on reset
    rst_n = 1'b0; in0 = nop; in2 = nop;
    #12;
    check("rst_a0", 32'(a0), 32'd0);
    check("rst_b0", 32'(b0), 32'd0);
    check("rst_stall0", 32'(stall0), 32'd0);
    check("rst_stall2", 32'(stall2), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_ready0", 32'(ready0), 32'd1);

    // Vector table on the EXTRA_STALL=0 instance
    for (int i = 0; i < NV; i++) begin
      @(negedge clk); in0 = vecs[i].in;
      #1 check($sformatf("v%0d_ready", i), 32'(ready0), 32'(vecs[i].ready));
      @(posedge clk); #1;
      check($sformatf("v%0d_a", i), 32'(a0), 32'(vecs[i].a));
      check($sformatf("v%0d_b", i), 32'(b0), 32'(vecs[i].b));
      check($sformatf("v%0d_stall", i), 32'(stall0), 32'(vecs[i].stall));
    end

    // EXTRA_STALL=2: three ready-low cycles, then the consumer reads the regfile
    @(negedge clk); in2 = lw7;
    @(posedge clk); #1;
    @(negedge clk); in2 = use7;
    low_cnt = 0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (ready2) got = 1'b1;
      else begin
        low_cnt++;
        @(posedge clk); #1;
        check($sformatf("es2_stall_c%0d", c), 32'(stall2), 32'd1);
        @(negedge clk);
      end
    end
    check("es2_accepted", 32'(got), 32'd1);
    check("es2_low_cycles", 32'(low_cnt), 32'd3);
    @(posedge clk); #1;
    check("es2_a", 32'(a2), 32'd0);
    check("es2_stall_end", 32'(stall2), 32'd0);
    @(negedge clk); in2 = nop;

    // EXTRA_STALL=2: flush during STALL returns to RUN at once
    @(negedge clk); in2 = lw7;
    @(posedge clk); #1;
    @(negedge clk); in2 = use7;
    #1 check("fl_ready_hz", 32'(ready2), 32'd0);
    @(posedge clk); #1 check("fl_stall_hz", 32'(stall2), 32'd1);
    @(negedge clk); in2 = use7; in2.fl = 1'b1;
    #1 check("fl_ready_fl", 32'(ready2), 32'd0);
    @(posedge clk); #1;
    check("fl_stall_fl", 32'(stall2), 32'd0);
    check("fl_a_fl", 32'(a2), 32'd0);
    @(negedge clk); in2 = use7;
    #1 check("fl_ready_run", 32'(ready2), 32'd1);
    @(posedge clk); #1;
    check("fl_a_run", 32'(a2), 32'd0);
    check("fl_stall_run", 32'(stall2), 32'd0);
    @(negedge clk); in2 = nop;

    // Reset mid-traffic: forwarding on dut0, stall on dut2
    @(negedge clk);
    in0 = ins(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); in2 = lw7;
    @(posedge clk); #1;
    @(negedge clk);
    in0 = ins(1, 5'd5, 5'd3, 5'd6, 1, 0, 0); in2 = use7;
    @(posedge clk); #1;
    check("mr_a0_pre", 32'(a0), 32'd1);
    check("mr_stall2_pre", 32'(stall2), 32'd1);
    @(negedge clk); in0 = nop;
    #2 rst_n = 1'b0;
    #1;
    check("mr_a0_rst", 32'(a0), 32'd0);
    check("mr_stall2_rst", 32'(stall2), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    in0 = ins(1, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    #1;
    check("mr_ready0", 32'(ready0), 32'd1);
    check("mr_ready2", 32'(ready2), 32'd1);
    @(posedge clk); #1;
    check("mr_a0_post", 32'(a0), 32'd0);
    check("mr_a2_post", 32'(a2), 32'd0);
    check("mr_stall2_post", 32'(stall2), 32'd0);
    @(negedge clk); in0 = nop; in2 = nop;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
